// File: rtl/forthsuper_pkg.sv
// forthsuper_pkg: shared types and default widths for the mb32 memory arbiter.
package forthsuper_pkg;
  localparam int MB32_AW = 15;
  localparam int MB32_DW = 32;
  typedef enum logic [1:0] {ARB, OWN0, OWN1} arb_st;
endpackage

// File: rtl/mb32_arbiter_if.sv
// mb32_arbiter_if: both requester ports plus the mb32 memory side; lock lines exist only with MB32_ARB_LOCK_EN.
interface mb32_arbiter_if #(
  parameter int AW = forthsuper_pkg::MB32_AW,
  parameter int DW = forthsuper_pkg::MB32_DW
);
  logic              req0, req1, we0, we1;
  logic [DW/8-1:0]   bmsk0, bmsk1;
  logic [AW-1:0]     ai0, ai1;
  logic [DW-1:0]     vi0, vi1;
  logic              gnt0, gnt1, rv0, rv1;
  logic [DW-1:0]     vo0, vo1;
  logic              m_we;
  logic [DW/8-1:0]   m_bmsk;
  logic [AW-1:0]     m_ai;
  logic [DW-1:0]     m_vi, m_vo;
`ifdef MB32_ARB_LOCK_EN
  logic              lock0, lock1;
`endif
  modport slave (
    input  req0, req1, we0, we1, bmsk0, bmsk1, ai0, ai1, vi0, vi1, m_vo,
`ifdef MB32_ARB_LOCK_EN
    input  lock0, lock1,
`endif
    output gnt0, gnt1, rv0, rv1, vo0, vo1, m_we, m_bmsk, m_ai, m_vi
  );
  modport master (
    output req0, req1, we0, we1, bmsk0, bmsk1, ai0, ai1, vi0, vi1, m_vo,
`ifdef MB32_ARB_LOCK_EN
    output lock0, lock1,
`endif
    input  gnt0, gnt1, rv0, rv1, vo0, vo1, m_we, m_bmsk, m_ai, m_vi
  );
endinterface

// File: rtl/mb32_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin chooser with an optional forced owner.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       force_en_i,
  input  logic       owner_i,
  output logic [1:0] gnt_o
);
  always_comb gnt_o = force_en_i ? (req_i & (owner_i ? 2'b10 : 2'b01))
                    : (&req_i ? (last_i ? 2'b01 : 2'b10) : req_i);
endmodule

// File: rtl/mb32_arbiter.sv
// mb32_arbiter: two-port round-robin arbiter for one mb32 memory block.
// Define MB32_ARB_LOCK_EN to add lock0/lock1 and the ARB/OWN0/OWN1 ownership FSM.
module mb32_arbiter
  import forthsuper_pkg::*;
#(
  parameter int AW = MB32_AW,
  parameter int DW = MB32_DW
) (
  input logic           clk,
  input logic           rst_n,
  mb32_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  logic [1:0]    pick, gnt, rv_d, rv_q;
  logic          last_q, force_en, owner, sel, any_g, we_s;
  logic [BW-1:0] bmsk_s;
  logic [AW-1:0] ai_s;
  logic [DW-1:0] vi_s;
`ifdef MB32_ARB_LOCK_EN
  arb_st st_q;
  // A held lock pins arbitration to its owner; dropping it arbitrates normally that same cycle.
  assign force_en = (st_q == OWN0 && bus.lock0) || (st_q == OWN1 && bus.lock1);
  assign owner    = st_q == OWN1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= ARB;
    else if (!force_en) st_q <= (gnt[0] && bus.lock0) ? OWN0 : (gnt[1] && bus.lock1) ? OWN1 : ARB;
`else
  assign force_en = 1'b0;
  assign owner    = 1'b0;
`endif
  rr_pick2 u_pick (
    .req_i      ({bus.req1, bus.req0}),
    .last_i     (last_q),
    .force_en_i (force_en),
    .owner_i    (owner),
    .gnt_o      (pick)
  );
  assign gnt = rst_n ? pick : 2'b00;
  always_comb begin
    sel    = gnt[1];
    any_g  = |gnt;
    we_s   = sel ? bus.we1 : bus.we0;
    bmsk_s = sel ? bus.bmsk1 : bus.bmsk0;
    ai_s   = sel ? bus.ai1 : bus.ai0;
    vi_s   = sel ? bus.vi1 : bus.vi0;
    rv_d   = gnt & ~{bus.we1, bus.we0};
  end
  assign bus.gnt0   = gnt[0];
  assign bus.gnt1   = gnt[1];
  assign bus.m_we   = any_g & we_s;
  assign bus.m_bmsk = (any_g & we_s) ? bmsk_s : '0;
  assign bus.m_ai   = any_g ? ai_s : '0;
  assign bus.m_vi   = any_g ? vi_s : '0;
  assign bus.rv0    = rv_q[0];
  assign bus.rv1    = rv_q[1];
  assign bus.vo0    = rst_n ? bus.m_vo : '0;
  assign bus.vo1    = rst_n ? bus.m_vo : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_q <= 1'b1;
      rv_q   <= 2'b00;
    end else begin
      if (any_g) last_q <= gnt[1];
      rv_q <= rv_d;
    end
endmodule

// File: tb/tb_mb32_arbiter.sv
// tb_mb32_arbiter: scenario tasks plus randomized traffic against a word-level memory/arbitration model.
module tb_mb32_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mb32_arbiter_if b ();
  mb32_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(b));

  logic [31:0] mem  [256];
  logic [31:0] gold [256];
  logic [1:0]  lk = 2'b00;
`ifdef MB32_ARB_LOCK_EN
  assign b.lock0 = lk[0];
  assign b.lock1 = lk[1];
`endif

  // Memory block with one-cycle read latency serving the DUT.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (b.m_we && b.m_bmsk[i]) mem[b.m_ai[7:0]][8*i +: 8] <= b.m_vi[8*i +: 8];
    b.m_vo <= mem[b.m_ai[7:0]];
  end

  int vectors = 0, miscompares = 0;
  int m_last = 1, m_own = -1;
  logic [1:0]  m_rv = 2'b00;
  logic [31:0] m_rd [2];

  function automatic logic [1:0] exp_gnt();
    logic [1:0] r;
    r = {b.req1, b.req0};
    if (!rst_n) return 2'b00;
    if (m_own >= 0 && lk[m_own]) return r & (2'b01 << m_own);
    if (r == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
    return r;
  endfunction

  // Advance one clock and update the model from the stimulus present at the edge.
  task automatic tick();
    logic [1:0] g; logic w; logic [3:0] m; logic [7:0] a; logic [31:0] v; logic [1:0] l; bit held; int p;
    g = exp_gnt(); held = (m_own >= 0) && lk[m_own]; l = lk;
    p = g[1] ? 1 : 0;
    w = p ? b.we1 : b.we0; m = p ? b.bmsk1 : b.bmsk0;
    a = p ? b.ai1[7:0] : b.ai0[7:0]; v = p ? b.vi1 : b.vi0;
    @(posedge clk);
    if (!rst_n) begin
      m_last = 1; m_own = -1; m_rv = 2'b00;
    end else begin
      m_rv = 2'b00;
      if (g != 2'b00) begin
        if (w) begin
          for (int i = 0; i < 4; i++) if (m[i]) gold[a][8*i +: 8] = v[8*i +: 8];
        end else begin
          m_rv[p] = 1'b1; m_rd[p] = gold[a];
        end
        m_last = p;
      end
      if (!held) m_own = (g[0] && l[0]) ? 0 : (g[1] && l[1]) ? 1 : -1;
    end
    #1;
  endtask

  task automatic set_port(int p, logic r, logic w, logic [3:0] m, logic [14:0] a, logic [31:0] v);
    if (p == 0) begin b.req0 = r; b.we0 = w; b.bmsk0 = m; b.ai0 = a; b.vi0 = v; end
    else        begin b.req1 = r; b.we1 = w; b.bmsk1 = m; b.ai1 = a; b.vi1 = v; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_port(0, 1, 0, 4'h0, 15'd1, 32'h0);
    set_port(1, 1, 0, 4'h0, 15'd2, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({b.gnt1, b.gnt0} !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got %b want 00", {b.gnt1, b.gnt0}); end
      vectors++;
      if (b.m_we !== 1'b0) begin miscompares++; $display("FAIL reset_m_we got %b want 0", b.m_we); end
      vectors++;
      if ({b.rv1, b.rv0} !== 2'b00) begin miscompares++; $display("FAIL reset_rv got %b want 00", {b.rv1, b.rv0}); end
      tick();
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({b.gnt1, b.gnt0} !== 2'b01) begin miscompares++; $display("FAIL reset_first_tie got %b want 01", {b.gnt1, b.gnt0}); end
    tick();
    set_port(0, 0, 0, 4'h0, 15'd0, 32'h0);
    set_port(1, 0, 0, 4'h0, 15'd0, 32'h0);
    @(negedge clk);
    vectors++;
    if ({b.rv1, b.rv0} !== 2'b01) begin miscompares++; $display("FAIL reset_first_rv got %b want 01", {b.rv1, b.rv0}); end
    tick();
  endtask

  task automatic test_single();
    set_port(0, 1, 1, 4'hF, 15'h0010, 32'hDEADBEEF);
    @(negedge clk);
    vectors++;
    if ({b.gnt1, b.gnt0, b.m_we, b.m_ai} !== {3'b011, 15'h0010}) begin
      miscompares++; $display("FAIL single_wr got gnt=%b we=%b ai=%h want 01/1/0010", {b.gnt1, b.gnt0}, b.m_we, b.m_ai); end
    tick();
    set_port(0, 1, 0, 4'hF, 15'h0010, 32'h0);
    @(negedge clk);
    vectors++;
    if ({b.gnt1, b.gnt0, b.m_we, b.m_bmsk} !== 7'b0100000) begin
      miscompares++; $display("FAIL single_rd got gnt=%b we=%b bmsk=%h want 01/0/0", {b.gnt1, b.gnt0}, b.m_we, b.m_bmsk); end
    tick();
    set_port(0, 0, 0, 4'h0, 15'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if ({b.rv0, b.vo0} !== {1'b1, 32'hDEADBEEF}) begin
      miscompares++; $display("FAIL single_rdata got rv0=%b vo0=%h want 1/deadbeef", b.rv0, b.vo0); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] eg, prev;
    prev = 2'b00;
    set_port(0, 1, 0, 4'h0, 15'd1, 32'h0);
    set_port(1, 1, 0, 4'h0, 15'd2, 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      eg = exp_gnt();
      vectors++;
      if ({b.gnt1, b.gnt0} !== eg || eg == prev) begin
        miscompares++; $display("FAIL contention_gnt c=%0d got %b want %b prev %b", c, {b.gnt1, b.gnt0}, eg, prev); end
      vectors++;
      if ({b.rv1, b.rv0} !== (c == 0 ? 2'b00 : prev)) begin
        miscompares++; $display("FAIL contention_rv c=%0d got %b want %b", c, {b.rv1, b.rv0}, c == 0 ? 2'b00 : prev); end
      if (m_rv[0]) begin vectors++; if (b.vo0 !== m_rd[0]) begin miscompares++; $display("FAIL contention_vo0 got %h want %h", b.vo0, m_rd[0]); end end
      if (m_rv[1]) begin vectors++; if (b.vo1 !== m_rd[1]) begin miscompares++; $display("FAIL contention_vo1 got %h want %h", b.vo1, m_rd[1]); end end
      prev = eg;
      tick();
    end
    set_port(0, 0, 0, 4'h0, 15'd0, 32'h0);
    set_port(1, 0, 0, 4'h0, 15'd0, 32'h0);
    tick();
  endtask

  task automatic test_bytemask();
    set_port(1, 1, 1, 4'hF, 15'd5, 32'h11223344);
    @(negedge clk);
    vectors++;
    if ({b.gnt1, b.gnt0, b.m_bmsk} !== 6'b10_1111) begin
      miscompares++; $display("FAIL bmsk_full got gnt=%b bmsk=%h want 10/f", {b.gnt1, b.gnt0}, b.m_bmsk); end
    tick();
    set_port(1, 1, 1, 4'h2, 15'd5, 32'h0000AB00);
    @(negedge clk);
    vectors++;
    if (b.m_bmsk !== 4'h2) begin miscompares++; $display("FAIL bmsk_part got %h want 2", b.m_bmsk); end
    tick();
    set_port(1, 1, 0, 4'hF, 15'd5, 32'h0);
    @(negedge clk);
    vectors++;
    if ({b.gnt1, b.m_we, b.m_bmsk} !== 6'b10_0000) begin
      miscompares++; $display("FAIL bmsk_read got gnt1=%b we=%b bmsk=%h want 1/0/0", b.gnt1, b.m_we, b.m_bmsk); end
    tick();
    set_port(1, 0, 0, 4'h0, 15'd0, 32'h0);
    @(negedge clk);
    vectors++;
    if ({b.rv1, b.vo1} !== {1'b1, 32'h1122AB44} || m_rd[1] !== 32'h1122AB44) begin
      miscompares++; $display("FAIL bmsk_rdata got rv1=%b vo1=%h want 1/1122ab44", b.rv1, b.vo1); end
    tick();
  endtask

`ifdef MB32_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b01; want[2] = 2'b00; want[3] = 2'b10;
    for (int c = 0; c < 4; c++) begin
      lk[0] = (c < 3);
      if (c == 0) set_port(0, 1, 0, 4'hF, 15'd3, 32'h0);
      else if (c == 1) set_port(0, 1, 1, 4'hF, 15'd3, 32'h55);
      else set_port(0, 0, 0, 4'h0, 15'd0, 32'h0);
      set_port(1, c > 0, 0, 4'h0, 15'd4, 32'h0);
      @(negedge clk);
      vectors++;
      if ({b.gnt1, b.gnt0} !== want[c] || exp_gnt() !== want[c]) begin
        miscompares++; $display("FAIL lock_gnt c=%0d got %b want %b", c, {b.gnt1, b.gnt0}, want[c]); end
      tick();
    end
    set_port(1, 0, 0, 4'h0, 15'd0, 32'h0);
    tick();
  endtask
`endif

  task automatic test_random();
    logic [1:0] eg, pend; logic [31:0] ev; logic ew; logic [3:0] em; logic [14:0] ea; int p;
    pend = 2'b00;
    for (int c = 0; c < 200; c++) begin
      for (int q = 0; q < 2; q++) begin
        if (pend[q] && $urandom_range(9) == 0) begin
          pend[q] = 1'b0; set_port(q, 0, 0, 4'h0, 15'd0, 32'h0);
        end else if (!pend[q]) begin
          pend[q] = $urandom_range(1);
          set_port(q, pend[q], $urandom_range(1), 4'($urandom), 15'($urandom_range(7)), $urandom);
        end
      end
      @(negedge clk);
      eg = exp_gnt();
      p = eg[1] ? 1 : 0;
      ew = (eg != 2'b00) && (p ? b.we1 : b.we0);
      em = ew ? (p ? b.bmsk1 : b.bmsk0) : 4'h0;
      ea = (eg != 2'b00) ? (p ? b.ai1 : b.ai0) : 15'd0;
      ev = (eg != 2'b00) ? (p ? b.vi1 : b.vi0) : 32'd0;
      vectors++;
      if ({b.gnt1, b.gnt0} !== eg) begin miscompares++; $display("FAIL rand_gnt c=%0d got %b want %b", c, {b.gnt1, b.gnt0}, eg); end
      vectors++;
      if ({b.m_we, b.m_bmsk, b.m_ai, b.m_vi} !== {ew, em, ea, ev}) begin
        miscompares++; $display("FAIL rand_mem c=%0d got %b/%h/%h/%h want %b/%h/%h/%h", c, b.m_we, b.m_bmsk, b.m_ai, b.m_vi, ew, em, ea, ev); end
      vectors++;
      if ({b.rv1, b.rv0} !== m_rv) begin miscompares++; $display("FAIL rand_rv c=%0d got %b want %b", c, {b.rv1, b.rv0}, m_rv); end
      if (m_rv[0]) begin vectors++; if (b.vo0 !== m_rd[0]) begin miscompares++; $display("FAIL rand_vo0 c=%0d got %h want %h", c, b.vo0, m_rd[0]); end end
      if (m_rv[1]) begin vectors++; if (b.vo1 !== m_rd[1]) begin miscompares++; $display("FAIL rand_vo1 c=%0d got %h want %h", c, b.vo1, m_rd[1]); end end
      pend = pend & ~eg;
      tick();
      for (int q = 0; q < 2; q++) if (eg[q]) set_port(q, 0, 0, 4'h0, 15'd0, 32'h0);
    end
    set_port(0, 0, 0, 4'h0, 15'd0, 32'h0);
    set_port(1, 0, 0, 4'h0, 15'd0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid_read();
    set_port(0, 1, 0, 4'h0, 15'h0010, 32'h0);
    @(negedge clk);
    vectors++;
    if ({b.gnt1, b.gnt0} !== 2'b01) begin miscompares++; $display("FAIL midrst_gnt got %b want 01", {b.gnt1, b.gnt0}); end
    tick();
    set_port(0, 0, 0, 4'h0, 15'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (b.rv0 !== 1'b0) begin miscompares++; $display("FAIL midrst_rv_in_reset got %b want 0", b.rv0); end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({b.rv1, b.rv0, b.gnt1, b.gnt0} !== 4'b0000) begin
        miscompares++; $display("FAIL midrst_after c=%0d got rv=%b gnt=%b want 00/00", c, {b.rv1, b.rv0}, {b.gnt1, b.gnt0}); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; gold[i] = 32'h0; end
    set_port(0, 0, 0, 4'h0, 15'd0, 32'h0);
    set_port(1, 0, 0, 4'h0, 15'd0, 32'h0);
    test_reset();
    test_single();
    test_contention();
    test_bytemask();
`ifdef MB32_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
